uart_tx_fsm_ctrl: RTL and testbench

//  Control stage of the UART transmitter, directly upstream of the registered 4:1 TX output mux.
//  - Accepts a parallel byte with a valid strobe.
//  - Serializes it LSB-first and computes the optional parity bit.
//  - Drives the mux select so the line carries start, data, parity and stop bits, one bit per CLK.
//  - CLK is the TX baud clock.
//  - Mux input map:
//    - in0 = 1'b0 (start)
//    - in1 = 1'b1 (stop/idle)
//    - in2 = ser_data
//    - in3 = par_bit

---
 rtl/uart_tx_pkg.sv | 39 +++
 rtl/uart_tx_parity_calc.sv | 22 ++
 rtl/uart_tx_fsm_ctrl.sv | 128 ++++++++++++
 tb/tb_uart_tx_fsm_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and the
// select codes of the registered 4:1 TX output mux.
package uart_tx_pkg;

  // FSM state encoding (3-bit)
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  // TX mux select codes; in0 = 0, in1 = 1, in2 = ser_data, in3 = par_bit
  localparam logic [1:0] MUX_SEL_START = 2'b00;
  localparam logic [1:0] MUX_SEL_STOP  = 2'b01;
  localparam logic [1:0] MUX_SEL_DATA  = 2'b10;
  localparam logic [1:0] MUX_SEL_PAR   = 2'b11;

  // Mux select that puts the bit belonging to a given state on the line.
  // IDLE and STOP both drive the line high.
  function automatic logic [1:0] mux_sel_for(input state_t st);
    logic [1:0] sel;
    sel = MUX_SEL_STOP;
    case (st)
      ST_START:  sel = MUX_SEL_START;
      ST_DATA:   sel = MUX_SEL_DATA;
      ST_PARITY: sel = MUX_SEL_PAR;
      default:   sel = MUX_SEL_STOP;
    endcase
    return sel;
  endfunction

  // A frame is in progress in every state except IDLE.
  function automatic logic busy_for(input state_t st);
    return (st != ST_IDLE);
  endfunction

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity of a payload word. PAR_TYP = 0 gives even parity
// (bit makes the total count of ones even), PAR_TYP = 1 gives odd parity.
module uart_tx_parity_calc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  PAR_TYP,
  output logic                  parity
);

  // XOR chain seeded with the parity type; the last tap is the parity bit.
  logic [DATA_WIDTH:0] chain;

  assign chain[0] = PAR_TYP;

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_chain
    assign chain[gi+1] = chain[gi] ^ P_DATA[gi];
  end

  assign parity = chain[DATA_WIDTH];

endmodule

// File: rtl/uart_tx_fsm_ctrl.sv
// UART TX control: accepts a parallel word, serialises it LSB-first and drives
// the select of the downstream registered output mux one bit per baud clock.
// Frame = start, DATA_WIDTH data bits, optional parity, stop. A request seen in
// STOP chains straight into the next frame with no idle bit.
module uart_tx_fsm_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic [1:0]            mux_sel,
  output logic                  busy
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  state_t                  state_q,   state_d;
  logic [DATA_WIDTH-1:0]   shift_q,   shift_d;
  logic [CNT_W-1:0]        cnt_q,     cnt_d;
  logic                    par_en_q,  par_en_d;
  logic                    par_bit_q, par_bit_d;
  logic [1:0]              mux_sel_q, mux_sel_d;
  logic                    busy_q,    busy_d;

  logic                    parity_w;
  logic                    accept_w;

  // PAR_TYP only matters at accept time; its effect is captured in par_bit,
  // so it needs no register of its own.
  uart_tx_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .P_DATA  (P_DATA),
    .PAR_TYP (PAR_TYP),
    .parity  (parity_w)
  );

  // A new word is taken only when the line is idle or finishing a stop bit.
  assign accept_w = DATA_VALID && ((state_q == ST_IDLE) || (state_q == ST_STOP));

  // State register: FSM, datapath and registered outputs, async active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      mux_sel_q <= MUX_SEL_STOP;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      mux_sel_q <= mux_sel_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic: transitions, shift register, bit counter and latches.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;

    case (state_q)
      ST_IDLE, ST_STOP: begin
        if (accept_w) begin
          state_d   = ST_START;
          shift_d   = P_DATA;
          par_en_d  = PAR_EN;
          par_bit_d = parity_w;
        end else begin
          state_d   = ST_IDLE;
        end
      end

      ST_START: begin
        state_d = ST_DATA;
        cnt_d   = '0;
      end

      ST_DATA: begin
        // Every data edge moves the next bit into shift_q[0]; the counter
        // saturates on the last bit instead of wrapping.
        shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
        if (cnt_q == CNT_LAST) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end

      ST_PARITY: begin
        state_d = ST_STOP;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: mux select and busy derived from the next state so that
  // their registered copies always describe the current state.
  always_comb begin
    mux_sel_d = mux_sel_for(state_d);
    busy_d    = busy_for(state_d);
  end

  assign ser_data = shift_q[0];
  assign par_bit  = par_bit_q;
  assign mux_sel  = mux_sel_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_fsm_ctrl.sv
// Directed bench for uart_tx_fsm_ctrl: a table of single frames plus
// hand-written sequences for back-to-back, ignored request and mid-frame reset.
module tb_uart_tx_fsm_ctrl;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       ser_data;
  logic       par_bit;
  logic [1:0] mux_sel;
  logic       busy;

  int total;
  int passed;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic       ep;   // expected par_bit
  } vec_t;

  vec_t vecs [6];

  uart_tx_fsm_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .ser_data   (ser_data),
    .par_bit    (par_bit),
    .mux_sel    (mux_sel),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_idle_mux"},  8'(mux_sel), 8'h01);
    chk({tag, "_idle_busy"}, 8'(busy),    8'h00);
  endtask

  // Called #1 after the accept edge (DUT in START); returns #1 after the edge
  // into STOP. pulse_k >= 0 raises a 0xFF request in that DATA cycle.
  task automatic check_frame(input logic [7:0] d, input logic pe, input logic ep,
                             input int pulse_k, input string tag);
    chk({tag, "_start_mux"},  8'(mux_sel), 8'h00);
    chk({tag, "_start_busy"}, 8'(busy),    8'h01);
    chk({tag, "_start_par"},  8'(par_bit), 8'(ep));
    for (int k = 0; k < 8; k++) begin
      step();
      if (pulse_k >= 0 && k == pulse_k + 1) DATA_VALID = 1'b0;
      chk($sformatf("%s_d%0d_mux", tag, k), 8'(mux_sel),  8'h02);
      chk($sformatf("%s_d%0d_ser", tag, k), 8'(ser_data), 8'(d[k]));
      if (k == pulse_k) begin
        DATA_VALID = 1'b1;
        P_DATA     = 8'hFF;
      end
    end
    if (pe) begin
      step();
      chk({tag, "_par_mux"}, 8'(mux_sel), 8'h03);
      chk({tag, "_par_bit"}, 8'(par_bit), 8'(ep));
    end
    step();
    chk({tag, "_stop_mux"},  8'(mux_sel), 8'h01);
    chk({tag, "_stop_busy"}, 8'(busy),    8'h01);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    P_DATA     = v.data;
    PAR_EN     = v.pe;
    PAR_TYP    = v.pt;
    DATA_VALID = 1'b1;
    step();
    DATA_VALID = 1'b0;
    check_frame(v.data, v.pe, v.ep, -1, tag);
    step();
    chk_idle(tag);
    $display("frame %s data=%h pe=%0d pt=%0d checks so far %0d/%0d",
             tag, v.data, v.pe, v.pt, passed, total);
  endtask

  initial begin
    total  = 0;
    passed = 0;

    vecs[0] = '{data: 8'hA5, pe: 1'b0, pt: 1'b0, ep: 1'b0};
    vecs[1] = '{data: 8'hA5, pe: 1'b1, pt: 1'b0, ep: 1'b0};
    vecs[2] = '{data: 8'hA5, pe: 1'b1, pt: 1'b1, ep: 1'b1};
    vecs[3] = '{data: 8'h07, pe: 1'b1, pt: 1'b0, ep: 1'b1};
    vecs[4] = '{data: 8'h00, pe: 1'b1, pt: 1'b1, ep: 1'b1};
    vecs[5] = '{data: 8'hFF, pe: 1'b0, pt: 1'b1, ep: 1'b1};

    // Reset held with a pending request: nothing may be accepted.
    RST        = 1'b0;
    DATA_VALID = 1'b1;
    P_DATA     = 8'hA5;
    PAR_EN     = 1'b1;
    PAR_TYP    = 1'b1;
    repeat (3) step();
    chk("reset_mux",  8'(mux_sel),  8'h01);
    chk("reset_busy", 8'(busy),     8'h00);
    chk("reset_par",  8'(par_bit),  8'h00);
    chk("reset_ser",  8'(ser_data), 8'h00);
    $display("reset held 3 cycles with DATA_VALID high");
    DATA_VALID = 1'b0;
    RST        = 1'b1;
    step();
    chk_idle("release");

    // Table of single frames
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back: request held high, payload changed during STOP.
    P_DATA     = 8'h3C;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b1;
    DATA_VALID = 1'b1;
    step();
    check_frame(8'h3C, 1'b0, 1'b1, -1, "b2b0");
    P_DATA = 8'hC3;
    step();
    check_frame(8'hC3, 1'b0, 1'b1, -1, "b2b1");
    DATA_VALID = 1'b0;
    step();
    chk_idle("b2b");
    $display("back-to-back 3C then C3 checks so far %0d/%0d", passed, total);

    // Request pulsed during DATA cycle 3 must be ignored.
    P_DATA     = 8'h5B;
    PAR_EN     = 1'b1;
    PAR_TYP    = 1'b0;
    DATA_VALID = 1'b1;
    step();
    DATA_VALID = 1'b0;
    check_frame(8'h5B, 1'b1, 1'b1, 3, "ign");
    step();
    chk_idle("ign");
    step();
    chk_idle("ign2");
    $display("ignored request in DATA cycle 3 checks so far %0d/%0d", passed, total);

    // Reset in DATA cycle 4 aborts the frame asynchronously.
    P_DATA     = 8'h3D;
    PAR_EN     = 1'b1;
    PAR_TYP    = 1'b0;
    DATA_VALID = 1'b1;
    step();
    DATA_VALID = 1'b0;
    chk("mrst_start_mux", 8'(mux_sel), 8'h00);
    chk("mrst_start_par", 8'(par_bit), 8'h01);
    repeat (5) step();
    chk("mrst_d4_mux", 8'(mux_sel),  8'h02);
    chk("mrst_d4_ser", 8'(ser_data), 8'h01);
    #2 RST = 1'b0;
    #1;
    chk("mrst_async_mux",  8'(mux_sel),  8'h01);
    chk("mrst_async_busy", 8'(busy),     8'h00);
    chk("mrst_async_par",  8'(par_bit),  8'h00);
    chk("mrst_async_ser",  8'(ser_data), 8'h00);
    step();
    RST = 1'b1;
    step();
    chk_idle("mrst_rel");
    step();
    chk_idle("mrst_rel2");
    $display("mid-frame reset in DATA cycle 4 checks so far %0d/%0d", passed, total);
    run_frame('{data: 8'h81, pe: 1'b1, pt: 1'b1, ep: 1'b1}, "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
